// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline buffer between decode and execute with valid/ready on both sides.
// Carries next-PC, both register operands, the sign-extended immediate, rt/rd and
// the decoded control word. Flush kills every held entry on the next edge.
// Build option ID_EX_SKID_EN: when defined, a skid register gives a 2-deep FIFO with
// a registered in_ready; when undefined, a single register with a pass-through
// in_ready (!out_valid | out_ready).
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_add,
   input  logic [DATA_W-1:0] in_dato1,
   input  logic [DATA_W-1:0] in_dato2,
   input  logic [DATA_W-1:0] in_extend,
   input  logic [REG_W-1:0]  in_rt,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_add,
   output logic [DATA_W-1:0] out_dato1,
   output logic [DATA_W-1:0] out_dato2,
   output logic [DATA_W-1:0] out_extend,
   output logic [REG_W-1:0]  out_rt,
   output logic [REG_W-1:0]  out_rd,
   output logic [CTRL_W-1:0] out_ctrl
);

   localparam int PAY_W = 4*DATA_W + 2*REG_W + CTRL_W;

   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] pay_p1;   // main register, drives out_*
   logic             vld_p1;
   logic             take_in;
   logic             take_out;

   assign in_pay = {in_add, in_dato1, in_dato2, in_extend, in_rt, in_rd, in_ctrl};
   assign {out_add, out_dato1, out_dato2, out_extend, out_rt, out_rd, out_ctrl} = pay_p1;
   assign out_valid = vld_p1;

   assign take_in  = in_valid & in_ready;
   assign take_out = vld_p1 & out_ready;

`ifdef ID_EX_SKID_EN
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_SKID  = 2'b11;

   logic [PAY_W-1:0] pay_p0;   // skid register, catches the entry behind a stall
   logic             vld_p0;

   // Ready depends only on the skid flop, so it never follows out_ready combinationally.
   assign in_ready = ~vld_p0;

   // Buffer state lives in the two valid bits: EMPTY / FULL / SKID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         pay_p0 <= '0;
         pay_p1 <= '0;
      end else if (flush) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         pay_p0 <= '0;
         pay_p1 <= '0;
      end else begin
         case ({vld_p0, vld_p1})
            ST_EMPTY: begin
               if (take_in) begin
                  pay_p1 <= in_pay;
                  vld_p1 <= 1'b1;
               end
            end
            ST_FULL: begin
               if (take_in && take_out) begin
                  pay_p1 <= in_pay;
               end else if (take_out) begin
                  vld_p1 <= 1'b0;
               end else if (take_in) begin
                  pay_p0 <= in_pay;
                  vld_p0 <= 1'b1;
               end
            end
            ST_SKID: begin
               if (take_out) begin
                  pay_p1 <= pay_p0;
                  vld_p0 <= 1'b0;
               end
            end
            default: begin
               // Skid valid without main valid cannot arise; fall back to empty skid.
               vld_p0 <= 1'b0;
            end
         endcase
      end
   end
`else
   // Single entry: a consuming execute stage frees the slot in the same cycle.
   assign in_ready = ~vld_p1 | out_ready;

   // Main register loads on accept and empties on a release with nothing behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         pay_p1 <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
         pay_p1 <= '0;
      end else if (take_in) begin
         pay_p1 <= in_pay;
         vld_p1 <= 1'b1;
      end else if (take_out) begin
         vld_p1 <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: accepted transactions are queued by a
// transaction-level FIFO model; a monitor compares the DUT outputs to the queue head.
module tb_id_ex_pipe_reg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 8;
`ifdef ID_EX_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int TW = 4*DATA_W + 2*REG_W + CTRL_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_add = '0, in_dato1 = '0, in_dato2 = '0, in_extend = '0;
   logic [REG_W-1:0]  in_rt = '0, in_rd = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_add, out_dato1, out_dato2, out_extend;
   logic [REG_W-1:0]  out_rt, out_rd;
   logic [CTRL_W-1:0] out_ctrl;

   id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_add(in_add), .in_dato1(in_dato1), .in_dato2(in_dato2), .in_extend(in_extend),
      .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_add(out_add), .out_dato1(out_dato1), .out_dato2(out_dato2), .out_extend(out_extend),
      .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl)
   );

   always #5 clk = ~clk;

   logic [TW-1:0] cur_in, cur_out;
   assign cur_in  = {in_add, in_dato1, in_dato2, in_extend, in_rt, in_rd, in_ctrl};
   assign cur_out = {out_add, out_dato1, out_dato2, out_extend, out_rt, out_rd, out_ctrl};

   // Scoreboard: transactions held by the buffer, oldest first.
   logic [TW-1:0] sb[$];
   bit zero_ok = 1'b1;   // buffer holds nothing since reset/flush: all data must read 0
   bit acc, rel;
   int n_chk  = 0;
   int n_pass = 0;

   function automatic bit exp_ready();
      if (DEPTH == 2) return (sb.size() < 2);
      else            return (sb.size() == 0) || out_ready;
   endfunction

   task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
   endtask

   // Reference model: FIFO of capacity DEPTH; flush or reset empties it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb.delete();
         zero_ok = 1'b1;
      end else begin
         acc = in_valid && exp_ready();
         rel = (sb.size() > 0) && out_ready;
         if (flush) begin
            sb.delete();
            zero_ok = 1'b1;
         end else begin
            if (rel) void'(sb.pop_front());
            if (acc) begin
               sb.push_back(cur_in);
               zero_ok = 1'b0;
            end
         end
      end
   end

   // Monitor: inputs change on negedge, so check 2 time units later, away from posedge.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         chk("out_valid", TW'(out_valid), TW'(sb.size() > 0));
         chk("in_ready", TW'(in_ready), TW'(exp_ready()));
         if (sb.size() > 0) chk("out_data", cur_out, sb[0]);
         else if (zero_ok)  chk("out_zero", cur_out, '0);
      end
   end

   task automatic drive(input bit v, input bit r, input bit f, input logic [DATA_W-1:0] add);
      @(negedge clk);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_add    = add;
      in_dato1  = $urandom;
      in_dato2  = $urandom;
      in_extend = $urandom;
      in_rt     = REG_W'($urandom);
      in_rd     = REG_W'($urandom);
      in_ctrl   = CTRL_W'($urandom_range(1, 255));
   endtask

   initial begin
      // Reset held for two cycles
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      rst_n = 1'b1;
      // Stream 4, 8, 12
      drive(1, 1, 0, 32'd4);
      drive(1, 1, 0, 32'd8);
      drive(1, 1, 0, 32'd12);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      // Backpressure: 0x10 then 0x14 offered while execute stalls
      drive(1, 0, 0, 32'h10);
      drive(1, 0, 0, 32'h14);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      // Fill, then flush with a simultaneous offer of 0x20
      drive(1, 0, 0, 32'h30);
      drive(1, 0, 0, 32'h34);
      drive(1, 0, 1, 32'h20);
      drive(0, 0, 0, 0);
      drive(0, 1, 0, 0);
      // Hold: stalled for 5 cycles while input data toggles
      drive(1, 0, 0, 32'h40);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h44);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      // Async reset while FULL
      drive(1, 0, 0, 32'h50);
      drive(0, 0, 0, 0);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", TW'(out_valid), '0);
      chk("async_rst_dato1", TW'(out_dato1), '0);
      @(negedge clk);
      rst_n = 1'b1;
      // Replace main on release with no bubble
      drive(1, 0, 0, 32'h60);
      drive(1, 1, 0, 32'h64);
      drive(1, 1, 0, 32'h68);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 31) == 0, $urandom);
      end
      // Drain
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
      #4;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline buffer with a valid/ready handshake on both sides, a synchronous flush and asynchronous active-low reset.
- Carries next-PC, both register-file read operands, the sign-extended immediate, rt/rd specifiers and a decoded control word.
- Sits between the decode stage and the execute stage.
- Generalises the plain always-capture stage register: it can stall, bubble and flush without losing or duplicating a transaction.

Parameters:
- DATA_W, 32, width of add/dato1/dato2/extend fields
- REG_W, 5, width of rt/rd register specifiers
- CTRL_W, 8, width of decoded control word

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  decode offers a transaction
- in_ready  out  1  buffer can accept this cycle
- in_add  in  DATA_W  next PC
- in_dato1  in  DATA_W  register read data 1
- in_dato2  in  DATA_W  register read data 2
- in_extend  in  DATA_W  sign-extended immediate
- in_rt  in  REG_W  instr[20:16]
- in_rd  in  REG_W  instr[15:11]
- in_ctrl  in  CTRL_W  control word
- out_valid  out  1  output holds a live transaction
- out_ready  in  1  execute consumes this cycle
- out_add, out_dato1, out_dato2, out_extend  out  DATA_W  registered copies
- out_rt, out_rd  out  REG_W  registered copies
- out_ctrl  out  CTRL_W  registered copy

Behaviour:
- Clock and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - Reset clears out_valid, skid valid and all data/ctrl registers to 0.
  - in_ready is 1 on the first edge after deassertion.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
  - Inputs must be sampled only on accept. Outputs must be stable while out_valid & !out_ready.
- Storage: main register (drives out_*) plus one skid register. State is derived from the two valid bits:
  - EMPTY: accept -> FULL, main<=in.
  - FULL: accept & release -> FULL, main<=in. Release only -> EMPTY. Accept only -> SKID, skid<=in. Neither -> hold.
  - SKID: in_ready=0. Release -> FULL, main<=skid. Otherwise hold.
- in_ready = !skid_valid, registered. It is never combinationally dependent on out_ready.
- Latency: accepted data appears on out_* the cycle after accept when the buffer was EMPTY, or was FULL with a release.
- Order: strict FIFO, depth 2. No transaction is dropped or duplicated except by flush.
- Flush:
  - Next edge: out_valid=0, skid valid=0, data/ctrl registers<=0 (a clean bubble).
  - Flush beats a simultaneous accept (input dropped) and a simultaneous release (the release still counts as taken by execute).
- Reset mid-operation: immediate asynchronous clear. Contents are lost; no partial state survives.
- Throughput: 1 transaction/cycle sustained while out_ready=1.

Optional Feature:
- Macro: ID_EX_SKID_EN.
- Defined: behaviour as above (2-entry, registered in_ready).
- Not defined:
  - No skid register; states EMPTY/FULL only.
  - in_ready = !out_valid | out_ready (combinational pass-through).
  - FULL with accept & release -> FULL, main<=in; other transitions as above.
  - Flush and reset rules unchanged.

Test Plan:
- Reset then stream: rst_n low 2 cycles, in_valid=1 with in_add=4,8,12 on consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after first accept; out_add=4,8,12 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 after first accept, offer in_add=0x10 then 0x14 -> 0x10 and 0x14 accepted, in_ready=0 next cycle (SKID). out_ready=1 -> 0x10 then 0x14 emitted; in_ready returns to 1.
- Flush in SKID state with simultaneous in_valid (in_add=0x20) -> next cycle out_valid=0, out_ctrl=0, out_add=0; 0x20 never emitted.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> out_valid and out_dato1 go 0 immediately without a clk edge.
- Hold stability: out_ready=0 for 5 cycles with FULL, in_dato2 toggling -> out_dato2 constant, out_rt/out_rd constant.
- ID_EX_SKID_EN undefined: FULL, out_ready=0 -> in_ready=0 same cycle. Raise out_ready -> in_ready=1 same cycle; next data replaces main with no bubble.
